// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and the
// step-count / counter-width derivations used by the top level.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int steps_f(input int width, input int digit);
    return width / digit;
  endfunction

  // Wide enough to hold STEPS itself, since the counter parks there in DONE.
  function automatic int cnt_w_f(input int steps);
    return $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple chain of full-adder cells; also exposes the
// carry into the top bit so the caller can derive signed overflow.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             c_in,
  output logic [DIGIT-1:0] s_d,
  output logic             c_out,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s_d  = '0;
    c[0] = c_in;
    for (int i = 0; i < DIGIT; i++) begin
      s_d[i]   = a_d[i] ^ b_d[i] ^ c[i];
      c[i+1]   = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
    end
  end

  assign c_out    = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock over WIDTH/DIGIT cycles,
// valid/ready on both sides. Define SERIAL_ADDER_OVF_EN to add the ovf output.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int STEPS = steps_f(WIDTH, DIGIT);
  localparam int CNT_W = cnt_w_f(STEPS);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(STEPS - 1);
  localparam logic [CNT_W-1:0] FINAL_CNT = CNT_W'(STEPS);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_msb_cin;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a_d      (a_q[DIGIT-1:0]),
    .b_d      (b_q[DIGIT-1:0]),
    .c_in     (carry_q),
    .s_d      (dig_sum),
    .c_out    (dig_cout),
    .c_msb_in (dig_msb_cin)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1, so the carry-in is forced high.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          res_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_q >> DIGIT;
        res_d[WIDTH-1 -: DIGIT] = dig_sum;
        carry_d = dig_cout;
        if (cnt_q == LAST_CNT) begin
          // Last digit holds the MSB, so its carries give cout and overflow.
          cnt_d   = FINAL_CNT;
          cout_d  = dig_cout;
          ovf_d   = dig_cout ^ dig_msb_cin;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = out_valid ? res_q : '0;
  assign cout      = out_valid & cout_q;

`ifdef SERIAL_ADDER_OVF_EN
  assign ovf = out_valid & ovf_q;
`else
  logic ovf_unused;
  assign ovf_unused = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit/1-digit and a 16-bit/4-digit
// instance checked against an arithmetic reference (ovf when SERIAL_ADDER_OVF_EN).
module tb_serial_adder;

  localparam int ST8  = 8;
  localparam int ST16 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    longint sum;
    bit     cout;
    bit     ovf;
    int     acc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];

  logic        iv8, ir8, cin8, sub8, ov8, or8, co8, busy8;
  logic [7:0]  a8, b8, s8;
  logic        iv16, ir16, cin16, sub16, ov16, or16, co16, busy16;
  logic [15:0] a16, b16, s16;
`ifdef SERIAL_ADDER_OVF_EN
  logic        ovf8, ovf16;
`endif

  serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf8),
`endif
    .busy(busy8)
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf16),
`endif
    .busy(busy16)
  );

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input int w, input longint a, input longint b,
                                 input bit cin, input bit sub);
    exp_t   e;
    longint m, full, sa, sb, sr;
    m  = longint'(1) << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (sub) begin
      full   = a - b;
      e.cout = (a >= b);
      sr     = sa - sb;
    end else begin
      full   = a + b + longint'(cin);
      e.cout = (full >= m);
      sr     = sa + sb + longint'(cin);
    end
    e.sum = (full + m) % m;
    e.ovf = (sr < -(m / 2)) || (sr > (m / 2 - 1));
    e.acc = 0;
    return e;
  endfunction

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input bit cin, input bit sub);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!ir8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept8_ready", ir8, 1);
    if (!ir8) return;
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; iv8 = 1'b1;
    @(posedge clk);
    #1;
    e = model(8, a, b, cin, sub);
    e.acc = cyc;
    q8.push_back(e);
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
  endtask

  task automatic drive16(input logic [15:0] a, input logic [15:0] b, input bit cin, input bit sub);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!ir16 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept16_ready", ir16, 1);
    if (!ir16) return;
    a16 = a; b16 = b; cin16 = cin; sub16 = sub; iv16 = 1'b1;
    @(posedge clk);
    #1;
    e = model(16, a, b, cin, sub);
    e.acc = cyc;
    q16.push_back(e);
    iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
  endtask

  // Monitors: compare the queue head every cycle the DUT shows a result,
  // pop on the output handshake.
  bit prev8 = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev8 = 1'b0;
    end else if (ov8) begin
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_valid8: out_valid=1 required 0 (nothing pending)");
      end else begin
        if (!prev8) chk("latency8", cyc - q8[0].acc, ST8);
        chk("sum8", s8, q8[0].sum);
        chk("cout8", co8, q8[0].cout);
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf8", ovf8, q8[0].ovf);
`endif
        chk("in_ready_done8", ir8, 0);
        if (or8) void'(q8.pop_front());
      end
      prev8 = 1'b1;
    end else begin
      chk("sum_hidden8", s8, 0);
      prev8 = 1'b0;
    end
  end

  bit prev16 = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev16 = 1'b0;
    end else if (ov16) begin
      if (q16.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_valid16: out_valid=1 required 0 (nothing pending)");
      end else begin
        if (!prev16) chk("latency16", cyc - q16[0].acc, ST16);
        chk("sum16", s16, q16[0].sum);
        chk("cout16", co16, q16[0].cout);
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf16", ovf16, q16[0].ovf);
`endif
        if (or16) void'(q16.pop_front());
      end
      prev16 = 1'b1;
    end else begin
      chk("sum_hidden16", s16, 0);
      prev16 = 1'b0;
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q8.size() + q16.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q8.size() + q16.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    iv8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; or8 = 1;
    iv16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0; or16 = 1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid8", ov8, 0);
    chk("rst_sum8", s8, 0);
    chk("rst_cout8", co8, 0);
    chk("rst_busy8", busy8, 0);
    chk("rst_in_ready8", ir8, 1);
    chk("rst_out_valid16", ov16, 0);
    chk("rst_busy16", busy16, 0);
    @(negedge clk);
    rst_n = 1'b1;

    drive8(8'h5A, 8'h3C, 1'b0, 1'b0);
    drive8(8'hFF, 8'h01, 1'b0, 1'b0);
    drive8(8'h7F, 8'h00, 1'b1, 1'b0);
    drive8(8'h10, 8'h20, 1'b1, 1'b1);
    drive8(8'h20, 8'h10, 1'b1, 1'b1);
    drive8(8'h00, 8'h80, 1'b0, 1'b1);
    for (int i = 0; i < 200; i++)
      drive8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    wait_drain();

    // Backpressure: result held in DONE while in_valid pulses are ignored.
    @(posedge clk); #1;
    or8 = 1'b0;
    drive8(8'hA5, 8'h5A, 1'b1, 1'b0);
    n = 0;
    while (!ov8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", ov8, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv8 = (i % 2 == 0);
      a8 = 8'($urandom); b8 = 8'($urandom);
    end
    @(negedge clk);
    iv8 = 1'b0;
    @(posedge clk); #1;
    or8 = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after", ir8, 1);
    chk("bp_valid_cleared", ov8, 0);
    chk("bp_busy_after", busy8, 0);
    repeat (12) @(posedge clk);

    // Reset during RUN after three digit steps.
    drive8(8'h33, 8'h44, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy8, 0);
    chk("midrst_out_valid", ov8, 0);
    chk("midrst_sum", s8, 0);
    chk("midrst_cout", co8, 0);
    chk("midrst_in_ready", ir8, 1);
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    drive8(8'h12, 8'h34, 1'b1, 1'b0);
    wait_drain();

    drive16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    drive16(16'h8000, 16'h0001, 1'b0, 1'b1);
    for (int i = 0; i < 1000; i++)
      drive16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor built on the team's full-adder cell: processes DIGIT bits per clock over WIDTH/DIGIT cycles.
- Replaces the single-bit combinational full adder wherever area matters more than latency, such as ALU datapaths and accumulators in the lab CPU.
- Uses a valid/ready handshake on input and output. Holds one operation at a time; no pipelining.

Parameters:
- WIDTH, 8, operand and result width in bits; must be at least 1.
- DIGIT, 1, bits added per cycle. WIDTH mod DIGIT must equal 0, otherwise elaboration fails.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands are presented.
- in_ready  out  1  block accepts an operation; combinational, equals (state==IDLE).
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  1 selects subtraction a-b.
- out_valid  out  1  result is held and valid.
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  result.
- cout  out  1  final carry out; for subtraction, 1 means no borrow.
- busy  out  1  state != IDLE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset state: IDLE, out_valid=0, sum=0, cout=0, busy=0, internal registers cleared, step counter=0.
- Constant STEPS = WIDTH/DIGIT. The counter is clog2(STEPS+1) bits wide.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with in_valid&in_ready, latch A=a and B=(sub ? ~b : b).
  - Latch carry = (sub ? 1 : cin). Clear the counter and go to RUN.
  - Operand ports are ignored when no handshake occurs.
- RUN:
  - Each edge adds the low DIGIT bits of A and B plus carry through a DIGIT-bit ripple of full-adder cells.
  - The resulting digit is shifted into the top of the result register, which shifts right by DIGIT. A and B also shift right by DIGIT.
  - Carry is updated and the counter increments.
  - After the STEPS-th RUN edge, go to DONE, set out_valid=1, and set cout to the final carry.
- DONE:
  - sum, cout and out_valid stay stable until out_ready=1 at an edge. That edge clears out_valid and returns to IDLE.
  - in_ready=0 in DONE, so a new operation is accepted at the earliest on the edge after the handshake.
- Latency: out_valid rises exactly STEPS edges after the accept edge.
  - Minimum issue interval is STEPS+2 cycles with out_ready tied high.
- sum is visible only in DONE; it is driven to 0 in IDLE and RUN.
- Arithmetic is modulo 2^WIDTH. There is no saturation.
- Boundaries:
  - WIDTH=DIGIT gives STEPS=1: a single RUN cycle.
  - The counter never wraps; it stops at STEPS.
  - in_valid asserted during RUN or DONE is ignored, and the operation is not queued.
  - Reset asserted mid-RUN or in DONE aborts immediately to reset values; no partial result appears.
  - out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- When defined, the block adds output port ovf, 1 bit:
  - Signed overflow, computed as the carry into the MSB XOR the carry out of the MSB.
  - Captured on the final RUN edge, valid with out_valid, and 0 on reset and in IDLE/RUN.
- When undefined, the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package serial_adder_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the STEPS and counter-width derivation macros/functions.
- One natural sub-module, digit_adder: a combinational DIGIT-bit ripple chain of full-adder cells.
  - Inputs: a_d, b_d, c_in. Outputs: s_d, c_out, and c_msb_in (the carry into the top bit, used by the ovf feature).

Test Plan:
- WIDTH=8, DIGIT=1: a=0x5A, b=0x3C, cin=0, sub=0 -> sum=0x96, cout=0, out_valid exactly 8 edges after accept; ovf=1 if enabled.
- WIDTH=8, DIGIT=1: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x00, cin=1 -> sum=0x80, ovf=1.
- Subtract: a=0x10, b=0x20, sub=1, cin=1 (ignored) -> sum=0xF0, cout=0. Then a=0x20, b=0x10 -> sum=0x10, cout=1.
- WIDTH=16, DIGIT=4: a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, out_valid 4 edges after accept.
  - Also run a random sweep of 1000 operands against a reference a+b+cin.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - Required: sum/cout stable, in_ready=0, and in_valid pulses ignored.
  - After out_ready=1, the next edge gives IDLE, with in_ready=1 the same cycle.
- Reset mid-RUN: assert rst_n=0 between clock edges at step 3 of 8.
  - Required: outputs go to 0 immediately, busy=0, and no out_valid after release.
  - A fresh operation afterwards completes correctly.
